// File: rtl/dw2_13_calc.sv
// dw2_13_calc: backprop delta weight dw2_13 = -(LR * delta2_1 * a1_3) in signed Q6.10.
// One shared 16x16 multiplier serves the GRAD and SCALE steps of a 4-state sequence.
module dw2_13_calc #(
    parameter logic signed [15:0] LR = 16'sb00_0000_0001_1001_10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic signed [15:0] delta2_1,
    input  logic signed [15:0] a1_3,
    output logic               busy,
    output logic signed [15:0] dw2_13,
    output logic               update_en
);
    typedef enum logic [1:0] {IDLE, GRAD, SCALE, OUT} state_t;
    state_t state, state_nx;
    logic signed [15:0] delta_l, a_l, grad, scaled, op_a, op_b;
    logic signed [31:0] prod, neg;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        return v > 32'sd32767 ? 16'sh7fff : v < -32'sd32768 ? 16'sh8000 : v[15:0];
    endfunction

    assign op_a = state == GRAD ? delta_l : grad;
    assign op_b = state == GRAD ? a_l : LR;
    assign prod = 32'(op_a) * 32'(op_b);
    assign neg  = -32'(scaled);

    always_comb begin
        state_nx = state == IDLE  ? (start ? GRAD : IDLE) :
                   state == GRAD  ? SCALE :
                   state == SCALE ? OUT : IDLE;
        busy = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            delta_l   <= '0;
            a_l       <= '0;
            grad      <= '0;
            scaled    <= '0;
            dw2_13    <= '0;
            update_en <= 1'b0;
        end else begin
            state     <= state_nx;
            update_en <= state == OUT;
            if (state == IDLE && start) begin
                delta_l <= delta2_1;
                a_l     <= a1_3;
            end
            if (state == GRAD) grad <= sat16(prod >>> 10);
            if (state == SCALE) scaled <= sat16(prod >>> 10);
            if (state == OUT) dw2_13 <= sat16(neg);
        end
    end
endmodule

// File: tb/tb_dw2_13_calc.sv
// tb_dw2_13_calc: scoreboard bench for dw2_13_calc, default LR and LR=1.0 instances.
module tb_dw2_13_calc;
    logic clk = 0;
    logic reset = 1;
    logic st [2];
    logic signed [15:0] dd [2];
    logic signed [15:0] aa [2];
    logic signed [15:0] dw [2];
    logic ue [2];
    logic bz [2];
    logic signed [15:0] q0 [$];
    logic signed [15:0] q1 [$];
    logic signed [15:0] last0 = 0, last1 = 0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    dw2_13_calc dut0 (.clk(clk), .reset(reset), .start(st[0]), .delta2_1(dd[0]), .a1_3(aa[0]),
                      .busy(bz[0]), .dw2_13(dw[0]), .update_en(ue[0]));
    dw2_13_calc #(.LR(16'sd1024)) dut1 (.clk(clk), .reset(reset), .start(st[1]), .delta2_1(dd[1]),
                      .a1_3(aa[1]), .busy(bz[1]), .dw2_13(dw[1]), .update_en(ue[1]));

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint sat(input longint x);
        return x > 32767 ? 32767 : x < -32768 ? -32768 : x;
    endfunction

    function automatic longint fdiv(input longint p);
        longint q = p / 1024;
        if (p < 0 && q * 1024 != p) q = q - 1;
        return q;
    endfunction

    // Reference: floor-rounded Q6.10 products, saturated at each step, then negated.
    function automatic logic signed [15:0] ref_dw(input int d, input int a, input int lr);
        longint g, s;
        g = sat(fdiv(longint'(d) * a));
        s = sat(fdiv(g * lr));
        return 16'(sat(-s));
    endfunction

    task automatic push(input int u, input logic signed [15:0] e);
        if (u == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic op(input int u, input logic signed [15:0] d, input logic signed [15:0] a,
                      input bit noise, input logic signed [15:0] e);
        @(negedge clk);
        st[u] = 1; dd[u] = d; aa[u] = a;
        push(u, e);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("busy_high", int'(bz[u]), 1);
            st[u] = noise; dd[u] = 16'($urandom); aa[u] = 16'($urandom);
        end
        @(negedge clk);
        chk("busy_low", int'(bz[u]), 0);
        st[u] = 0;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (reset) begin
            last0 = 0; last1 = 0;
        end else begin
            if (ue[0]) begin
                if (q0.size() == 0) begin
                    chk("unexpected_update0", 1, 0);
                    last0 = dw[0];
                end else begin
                    last0 = q0.pop_front();
                    chk("dw0", int'(dw[0]), int'(last0));
                end
            end else chk("hold0", int'(dw[0]), int'(last0));
            if (ue[1]) begin
                if (q1.size() == 0) begin
                    chk("unexpected_update1", 1, 0);
                    last1 = dw[1];
                end else begin
                    last1 = q1.pop_front();
                    chk("dw1", int'(dw[1]), int'(last1));
                end
            end else chk("hold1", int'(dw[1]), int'(last1));
        end
    end

    initial begin
        logic signed [15:0] d, a;
        for (int i = 0; i < 2; i++) begin
            st[i] = 0; dd[i] = 0; aa[i] = 0;
        end
        repeat (2) @(negedge clk);
        chk("rst_dw", int'(dw[0]), 0);
        chk("rst_ue", int'(ue[0]), 0);
        chk("rst_busy", int'(bz[0]), 0);
        reset = 0;
        op(0, 16'sd1024, 16'sd512, 0, -16'sd51);
        op(0, -16'sd1, 16'sd1024, 0, 16'sd1);
        op(0, 16'sd32767, 16'sd32767, 0, -16'sd3263);
        op(1, -16'sd32768, 16'sd1024, 0, 16'sd32767);
        op(0, 16'sd2048, 16'sd1024, 1, -16'sd204);
        for (int i = 0; i < 24; i++) begin
            int u = i % 2;
            d = ($urandom % 3 == 0) ? 16'($signed($urandom_range(0, 4096)) - 2048) : 16'($urandom);
            a = 16'($urandom);
            op(u, d, a, 1'($urandom), ref_dw(d, a, u ? 1024 : 102));
        end
        // Reset landing in SCALE must abort the computation silently.
        @(negedge clk);
        st[0] = 1; dd[0] = 16'sd4096; aa[0] = 16'sd4096;
        @(negedge clk);
        st[0] = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("abort_dw", int'(dw[0]), 0);
        chk("abort_ue", int'(ue[0]), 0);
        chk("abort_busy", int'(bz[0]), 0);
        reset = 0;
        repeat (4) @(negedge clk);
        chk("abort_no_update_dw", int'(dw[0]), 0);
        op(0, 16'sd1024, 16'sd512, 0, -16'sd51);
        // Continuous start: one result every 4 cycles.
        @(negedge clk);
        st[0] = 1; dd[0] = 16'sd3000; aa[0] = -16'sd700;
        for (int k = 0; k < 3; k++) push(0, ref_dw(3000, -700, 102));
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("held_ue", int'(ue[0]), int'(k % 4 == 0 && k > 0));
        end
        st[0] = 0;
        for (int k = 0; k < 40 && (q0.size() != 0 || q1.size() != 0); k++) @(negedge clk);
        chk("drain", q0.size() + q1.size(), 0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
